// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID handshake, write-back port and registered ID/EX outputs.
// slave = the decode stage, master = its environment (fetch, execute, write-back).
interface id_stage_pipe_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RA_W = $clog2(NREGS);

    logic            if_valid;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;
    logic            ex_ready;
    logic            wb_wr_en;
    logic [RA_W-1:0] wb_rd_addr;
    logic [XLEN-1:0] wb_wr_data;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [RA_W-1:0] rd_addr;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic            illegal;

    modport slave (
        input  if_valid, if_inst, if_pc, flush, ex_ready,
               wb_wr_en, wb_rd_addr, wb_wr_data,
        output id_ready, id_valid, id_pc, rs1_data, rs2_data, imm,
               opcode, func3, func7, rd_addr, rs1_addr, rs2_addr, illegal
    );

    modport master (
        output if_valid, if_inst, if_pc, flush, ex_ready,
               wb_wr_en, wb_rd_addr, wb_wr_data,
        input  id_ready, id_valid, id_pc, rs1_data, rs2_data, imm,
               opcode, func3, func7, rd_addr, rs1_addr, rs2_addr, illegal
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined RV32 decode stage: handshake, field decode, register file, immediates, load-use interlock.
// Optional macro ID_WB_BYPASS_EN: write-back data is written through into operands captured that cycle.
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    id_stage_pipe_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [5:0] NREGS_W6  = 6'(NREGS);

    logic [31:0]     inst;
    logic [6:0]      in_op;
    logic [2:0]      in_f3;
    logic [6:0]      in_f7;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [RA_W-1:0] rd_a;
    logic [RA_W-1:0] rs1_a;
    logic [RA_W-1:0] rs2_a;

    assign inst   = bus.if_inst;
    assign in_op  = inst[6:0];
    assign in_f3  = inst[14:12];
    assign in_f7  = inst[31:25];
    assign in_rd  = inst[11:7];
    assign in_rs1 = inst[19:15];
    assign in_rs2 = inst[24:20];
    assign rd_a   = in_rd[RA_W-1:0];
    assign rs1_a  = in_rs1[RA_W-1:0];
    assign rs2_a  = in_rs2[RA_W-1:0];

    logic        known;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] imm32;

    always_comb begin
        known   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm32   = '0;
        case (in_op)
            OP_REG: begin
                known   = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                known   = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                known   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                known   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                known   = 1'b1;
                use_rd  = 1'b1;
                imm32   = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                known   = 1'b1;
                use_rd  = 1'b1;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] imm_ext;
    logic            illegal_in;

    assign imm_ext    = XLEN'($signed(imm32));
    // Register indices above the RV32E range are flagged, not trapped; the instruction still flows.
    assign illegal_in = !known
                      || (use_rd  && ({1'b0, in_rd}  >= NREGS_W6))
                      || (use_rs1 && ({1'b0, in_rs1} >= NREGS_W6))
                      || (use_rs2 && ({1'b0, in_rs2} >= NREGS_W6));

    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.wb_wr_en && (bus.wb_rd_addr != '0)) begin
            rf[bus.wb_rd_addr] <= bus.wb_wr_data;
        end
    end

    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;

    always_comb begin
        rs1_rd = (rs1_a == '0) ? '0 : rf[rs1_a];
        rs2_rd = (rs2_a == '0) ? '0 : rf[rs2_a];
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_wr_en && (rs1_a != '0) && (bus.wb_rd_addr == rs1_a)) rs1_rd = bus.wb_wr_data;
        if (bus.wb_wr_en && (rs2_a != '0) && (bus.wb_rd_addr == rs2_a)) rs2_rd = bus.wb_wr_data;
`endif
    end

    logic            id_valid_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [6:0]      opcode_q;
    logic [2:0]      func3_q;
    logic [6:0]      func7_q;
    logic [RA_W-1:0] rd_addr_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic            illegal_q;

    // Load-use: the held load's destination is read by the incoming instruction.
    logic [4:0] held_rd;
    logic       hazard;
    logic       id_ready_c;
    logic       accept;

    assign held_rd    = 5'(rd_addr_q);
    assign hazard     = id_valid_q && (opcode_q == OP_LOAD) && (rd_addr_q != '0) && bus.if_valid
                      && ((use_rs1 && (in_rs1 == held_rd)) || (use_rs2 && (in_rs2 == held_rd)));
    assign id_ready_c = (!id_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign accept     = bus.if_valid && id_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            opcode_q   <= '0;
            func3_q    <= '0;
            func7_q    <= '0;
            rd_addr_q  <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            illegal_q  <= 1'b0;
        end else if (bus.flush) begin
            id_valid_q <= 1'b0;
        end else if (accept) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= bus.if_pc;
            rs1_data_q <= rs1_rd;
            rs2_data_q <= rs2_rd;
            imm_q      <= imm_ext;
            opcode_q   <= in_op;
            func3_q    <= in_f3;
            func7_q    <= in_f7;
            rd_addr_q  <= rd_a;
            rs1_addr_q <= rs1_a;
            rs2_addr_q <= rs2_a;
            illegal_q  <= illegal_in;
        end else if (bus.ex_ready) begin
            id_valid_q <= 1'b0;
        end
    end

    assign bus.id_ready = id_ready_c;
    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.rs1_data = rs1_data_q;
    assign bus.rs2_data = rs2_data_q;
    assign bus.imm      = imm_q;
    assign bus.opcode   = opcode_q;
    assign bus.func3    = func3_q;
    assign bus.func7    = func7_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rs1_addr = rs1_addr_q;
    assign bus.rs2_addr = rs2_addr_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic against a behavioural model,
// and a small RV32E (NREGS=16) instance.
module tb_id_stage_pipe;
    localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, AUIPC = 7'b0010111,
                           STORE = 7'b0100011, OPREG = 7'b0110011, LUI = 7'b0110111,
                           BRANCH = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset16;

    id_stage_pipe_if #(.XLEN(32), .NREGS(32)) bus ();
    id_stage_pipe_if #(.XLEN(32), .NREGS(16)) bus16 ();

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    id_stage_pipe #(.XLEN(32), .NREGS(16)) dut16 (.clk(clk), .reset(reset16), .bus(bus16));

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
    } exp_t;

    logic [31:0] m_rf [32];
    bit          m_valid;
    exp_t        m_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction format letter, 0 for unknown opcodes.
    function automatic byte kind(input logic [6:0] op);
        case (op)
            OPREG:              return "R";
            LOAD, OPIMM, JALR:  return "I";
            STORE:              return "S";
            BRANCH:             return "B";
            LUI, AUIPC:         return "U";
            JAL:                return "J";
            default:            return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = 0;
        case (kind(i[6:0]))
            "I": begin v = int'(i[31:20]); if (i[31]) v -= 4096; end
            "S": begin v = int'(i[31:25]) * 32 + int'(i[11:7]); if (i[31]) v -= 4096; end
            "B": begin
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            "U": v = int'(i & 32'hFFFF_F000);
            "J": begin
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (i[31]) v -= (1 << 20);
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit reads1(input byte k);
        return k == "R" || k == "I" || k == "S" || k == "B";
    endfunction
    function automatic bit reads2(input byte k);
        return k == "R" || k == "S" || k == "B";
    endfunction
    function automatic bit writes_rd(input byte k);
        return k == "R" || k == "I" || k == "U" || k == "J";
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input int n);
        exp_t e;
        byte  k;
        k      = kind(i[6:0]);
        e      = '0;
        e.pc   = pc;
        e.imm  = ref_imm(i);
        e.op   = i[6:0];
        e.f3   = i[14:12];
        e.f7   = i[31:25];
        e.rd   = i[11:7];
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.ill  = (k == 0) || (writes_rd(k) && int'(e.rd) >= n)
              || (reads1(k) && int'(e.rs1) >= n) || (reads2(k) && int'(e.rs2) >= n);
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_wr_en && bus.wb_rd_addr == a) return bus.wb_wr_data;
`endif
        return m_rf[a];
    endfunction

    function automatic bit model_ready();
        byte k;
        bit  haz;
        k   = kind(bus.if_inst[6:0]);
        haz = m_valid && m_out.op == LOAD && m_out.rd != 0 && bus.if_valid
              && ((reads1(k) && bus.if_inst[19:15] == m_out.rd)
               || (reads2(k) && bus.if_inst[24:20] == m_out.rd));
        return (!m_valid || bus.ex_ready) && !haz && !bus.flush;
    endfunction

    task automatic check_outputs();
        chk("id_valid", bus.id_valid, m_valid);
        if (m_valid) begin
            chk("id_pc", bus.id_pc, m_out.pc);
            chk("rs1_data", bus.rs1_data, m_out.rs1d);
            chk("rs2_data", bus.rs2_data, m_out.rs2d);
            chk("imm", bus.imm, m_out.imm);
            chk("opcode", bus.opcode, m_out.op);
            chk("func3", bus.func3, m_out.f3);
            chk("func7", bus.func7, m_out.f7);
            chk("rd_addr", bus.rd_addr, m_out.rd);
            chk("rs1_addr", bus.rs1_addr, m_out.rs1);
            chk("rs2_addr", bus.rs2_addr, m_out.rs2);
            chk("illegal", bus.illegal, m_out.ill);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic exr, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        bus.if_valid   = v;
        bus.if_inst    = inst;
        bus.if_pc      = pc;
        bus.ex_ready   = exr;
        bus.flush      = fl;
        bus.wb_wr_en   = we;
        bus.wb_rd_addr = wa;
        bus.wb_wr_data = wd;
    endtask

    task automatic step();
        bit   rdy;
        bit   acc;
        exp_t n;
        #1;
        rdy = model_ready();
        chk("id_ready", bus.id_ready, rdy);
        acc = bus.if_valid && rdy;
        n   = '0;
        if (acc) begin
            n      = ref_decode(bus.if_inst, bus.if_pc, 32);
            n.rs1d = m_read(n.rs1);
            n.rs2d = m_read(n.rs2);
        end
        @(posedge clk);
        if (bus.flush) m_valid = 0;
        else if (acc) begin m_valid = 1; m_out = n; end
        else if (bus.ex_ready) m_valid = 0;
        if (bus.wb_wr_en && bus.wb_rd_addr != 0) m_rf[bus.wb_rd_addr] = bus.wb_wr_data;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_valid = 0;
        m_out   = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_pc", bus.id_pc, 0);
        chk("rst_rs1_data", bus.rs1_data, 0);
        chk("rst_rs2_data", bus.rs2_data, 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_func3", bus.func3, 0);
        chk("rst_func7", bus.func7, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_rs1_addr", bus.rs1_addr, 0);
        chk("rst_rs2_addr", bus.rs2_addr, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_id_ready", bus.id_ready, 1);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] i;
        logic [6:0]  op;
        case ($urandom_range(0, 11))
            0, 1:    op = LOAD;
            2:       op = OPIMM;
            3, 4:    op = OPREG;
            5:       op = STORE;
            6:       op = BRANCH;
            7:       op = LUI;
            8:       op = AUIPC;
            9:       op = JAL;
            10:      op = JALR;
            default: op = 7'b1111111;
        endcase
        i        = $urandom;
        i[6:0]   = op;
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    initial begin
        reset16           = 1'b1;
        bus16.if_valid    = 1'b0;
        bus16.if_inst     = 32'h0;
        bus16.if_pc       = 32'h0;
        bus16.ex_ready    = 1'b1;
        bus16.flush       = 1'b0;
        bus16.wb_wr_en    = 1'b0;
        bus16.wb_rd_addr  = 4'd0;
        bus16.wb_wr_data  = 32'h0;

        do_reset();

        // ADDI x1,x0,-5
        drive(1, 32'hFFB00093, 32'h100, 1, 0, 0, 5'd0, 32'h0);
        step();
        chk("addi_valid", bus.id_valid, 1);
        chk("addi_imm", bus.imm, 32'hFFFF_FFFB);
        chk("addi_rd", bus.rd_addr, 1);
        chk("addi_rs1_data", bus.rs1_data, 0);
        chk("addi_illegal", bus.illegal, 0);
        chk("addi_pc", bus.id_pc, 32'h100);

        // x5 = DEADBEEF, then BEQ x5,x0,-8
        drive(0, 32'h0, 32'h0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
        step();
        drive(1, 32'hFE028CE3, 32'h104, 1, 0, 0, 5'd0, 32'h0);
        step();
        chk("beq_rs1_data", bus.rs1_data, 32'hDEAD_BEEF);
        chk("beq_imm", bus.imm, 32'hFFFF_FFF8);
        chk("beq_opcode", bus.opcode, 7'b1100011);

        // LW x3,0(x2) then dependent ADD x4,x3,x1: one bubble
        drive(1, 32'h00012183, 32'h108, 1, 0, 0, 5'd0, 32'h0);
        step();
        drive(1, 32'h00118233, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
        #1;
        chk("hz_ready", bus.id_ready, 0);
        step();
        chk("hz_bubble", bus.id_valid, 0);
        step();
        chk("hz_add_valid", bus.id_valid, 1);
        chk("hz_add_rs1", bus.rs1_addr, 3);
        chk("hz_add_pc", bus.id_pc, 32'h10C);

        // LW then independent ADD x4,x0,x1: no bubble
        drive(1, 32'h00012183, 32'h110, 1, 0, 0, 5'd0, 32'h0);
        step();
        drive(1, 32'h00100233, 32'h114, 1, 0, 0, 5'd0, 32'h0);
        step();
        chk("nohz_valid", bus.id_valid, 1);
        chk("nohz_pc", bus.id_pc, 32'h114);

        // Stall three cycles, then flush while held
        drive(1, 32'hFFB00093, 32'h200, 1, 0, 0, 5'd0, 32'h0);
        step();
        drive(1, 32'hFE028CE3, 32'h204, 0, 0, 0, 5'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_pc", bus.id_pc, 32'h200);
            chk("stall_imm", bus.imm, 32'hFFFF_FFFB);
            chk("stall_ready", bus.id_ready, 0);
        end
        drive(1, 32'hFE028CE3, 32'h204, 0, 1, 0, 5'd0, 32'h0);
        step();
        chk("flush_valid", bus.id_valid, 0);
        drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        step();
        chk("flush_no_capture", bus.id_valid, 0);

        // Same-cycle write-back of x7 while ADD x8,x7,x7 is accepted
        drive(0, 32'h0, 32'h0, 1, 0, 1, 5'd7, 32'h55);
        step();
        drive(1, 32'h00738433, 32'h300, 1, 0, 1, 5'd7, 32'h1234);
        step();
`ifdef ID_WB_BYPASS_EN
        chk("wb_rs1", bus.rs1_data, 32'h1234);
        chk("wb_rs2", bus.rs2_data, 32'h1234);
`else
        chk("wb_rs1", bus.rs1_data, 32'h55);
        chk("wb_rs2", bus.rs2_data, 32'h55);
`endif

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            step();
        end

        // Reset with an instruction held
        drive(1, 32'hFFB00093, 32'h400, 0, 0, 0, 5'd0, 32'h0);
        step();
        chk("midrst_held", bus.id_valid, 1);
        do_reset();

        // RV32E instance
        @(posedge clk);
        #1;
        chk("e_rst_valid", bus16.id_valid, 0);
        reset16          = 1'b0;
        bus16.wb_wr_en   = 1'b1;
        bus16.wb_rd_addr = 4'd0;
        bus16.wb_wr_data = 32'hFFFF;
        bus16.if_valid   = 1'b1;
        bus16.if_inst    = 32'h002088B3;
        bus16.if_pc      = 32'h500;
        @(posedge clk);
        #1;
        chk("e_x17_valid", bus16.id_valid, 1);
        chk("e_x17_illegal", bus16.illegal, 1);
        bus16.wb_wr_en = 1'b0;
        bus16.if_inst  = 32'h000001B3;
        bus16.if_pc    = 32'h504;
        @(posedge clk);
        #1;
        chk("e_x0_rs1", bus16.rs1_data, 0);
        chk("e_x0_rs2", bus16.rs2_data, 0);
        chk("e_legal", bus16.illegal, 0);
        chk("e_pc", bus16.id_pc, 32'h504);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
